spi_ram_arbiter: RTL and testbench
==================================

// Module: spi_ram_arbiter
// PURPOSE
//  Shares the single-port command RAM between two requesters: the SPI slave and a local host port.
//  - Both requesters issue 10-bit RAM commands.
//  - The RAM keeps shared write/read address registers, so an address+data pair must reach it atomically.
//  - The block therefore locks the RAM to one owner from its address command until its data command, and routes read data back to that owner.
//  - Sits between spi_slave outputs, a host master and the RAM din/rx_valid/dout/tx_valid bus.
// PARAMETERS
//  DATA_W       8   RAM word width; command width = DATA_W+2 ([9:8] opcode: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data)
//  TIMEOUT_CYC  64  cycles a lock may sit without its data command (ARB_TIMEOUT_EN only)
// PORTS
//  clk           in   1         clock, all logic on rising edge
//  rst_n         in   1         asynchronous active-low reset
//  spi_rx_data   in   DATA_W+2  command from SPI slave, stable while spi_rx_valid high
//  spi_rx_valid  in   1         level; high for many cycles per frame
//  spi_tx_data   out  DATA_W    read data to SPI slave
//  spi_tx_valid  out  1         1-cycle pulse with spi_tx_data
//  host_req      in   1         host command request, host_cmd valid while high
//  host_cmd      in   DATA_W+2  host command
//  host_gnt      out  1         command accepted this cycle when host_req && host_gnt
//  host_rdata    out  DATA_W    read data to host
//  host_rvalid   out  1         1-cycle pulse with host_rdata
//  ram_din       out  DATA_W+2  command to RAM
//  ram_rx_valid  out  1         1-cycle pulse per issued command
//  ram_dout      in   DATA_W    RAM read data
//  ram_tx_valid  in   1         RAM read-data valid, any latency >= 1
//  owner         out  2         00 none, 01 SPI, 10 host
//  spi_overflow  out  1         sticky; SPI command dropped
//  lock_timeout  out  1         1-cycle pulse on forced release; tied 0 without macro
// BEHAVIOUR
//  Reset: all outputs 0. Also clears state, buffer, last-winner (= host) and overflow.
//   Reset mid-transaction abandons it; no read pulse follows.
//  SPI capture:
//   - spi_rx_valid rising edge (registered previous value 0, current 1) loads spi_rx_data into a 1-entry buffer and sets spi_pend.
//   - Edge while spi_pend is set and the buffer is not issuing that cycle: the new command is dropped and spi_overflow is set.
//   - Issue and capture in the same cycle: the new command is kept, no overflow.
//  FSM states: IDLE, LOCK_SPI, LOCK_HOST, RD_WAIT.
//   IDLE:
//    - Candidates are spi_pend and host_req.
//    - Both present: grant the requester that did not win last (round-robin).
//    - Winner's command is issued. host_gnt is combinational, asserted only for the cycle the host wins.
//   LOCK_x:
//    - Only owner x is served. The other requester waits; SPI commands stay buffered, host_gnt=0.
//   Transitions on an issued command (from IDLE or own LOCK):
//    - opcode 00/10 -> LOCK_x. A repeat address command keeps the lock.
//    - opcode 01 -> IDLE (release).
//    - opcode 11 -> RD_WAIT, remembering the requester.
//    - A data command from IDLE is a single-shot access.
//   RD_WAIT:
//    - Nothing issued; host_gnt=0.
//    - On ram_tx_valid: ram_dout is copied to {spi_tx_data, spi_tx_valid} or {host_rdata, host_rvalid}, registered (+1 cycle).
//    - Then -> IDLE.
//  Latency:
//   - Host: ram_rx_valid high the cycle after host_req && host_gnt.
//   - SPI: ram_rx_valid 2 cycles after the rx_valid rise, when not blocked.
//   - Read data to owner: 1 cycle after ram_tx_valid.
//  Output timing:
//   - ram_din holds its last value between pulses.
//   - owner reflects the current lock; during RD_WAIT it shows the read requester.
//  Last-winner updates on every IDLE grant.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - A TIMEOUT_CYC counter runs in LOCK_SPI/LOCK_HOST, cleared on every owner command.
//   - On reaching TIMEOUT_CYC: -> IDLE and pulse lock_timeout.
//   - Counter width $clog2(TIMEOUT_CYC+1).
//  Not defined: locks are held indefinitely; no counter; lock_timeout=0.
// TESTING
//  T1: host 0x005 then 0x1A5 (gnt each cycle) -> ram_din 0x005, 0x1A5 on consecutive pulses; owner 10 then 00.
//  T2: SPI 0x203, then host_req 0x0FF pending, then SPI 0x300 -> host_gnt held 0 until SPI read returns.
//      ram_dout 0x5C -> spi_tx_data 0x5C pulse; then host granted.
//  T3: reset to last=host, spi_pend and host_req raised same cycle in IDLE -> SPI wins.
//      Repeat the tie -> host wins.
//  T4: two SPI rx_valid rises while host holds lock -> first issued after release; second dropped; spi_overflow=1 until reset.
//  T5: ARB_TIMEOUT_EN, TIMEOUT_CYC=8, host issues 0x010 then idles -> lock_timeout pulse 8 cycles later, owner 00.
//      Without the macro, owner stays 10.
//  T6: rst_n low during RD_WAIT -> all outputs 0 immediately; ram_tx_valid afterwards produces no rvalid.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Locks the shared command RAM to the SPI slave or the host from address command to data command.
// Optional ARB_TIMEOUT_EN: a lock idle for TIMEOUT_CYC cycles is force-released.
//
// state        | meaning
// S_IDLE       | no owner; round-robin between buffered SPI command and host_req
// S_LOCK_SPI   | SPI issued an address command; only SPI is served
// S_LOCK_HOST  | host issued an address command; only host is served
// S_RD_WAIT    | read-data command issued; waiting for ram_tx_valid to route back
module spi_ram_arbiter #(
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W+1:0] spi_rx_data,
   input  logic              spi_rx_valid,
   output logic [DATA_W-1:0] spi_tx_data,
   output logic              spi_tx_valid,
   input  logic              host_req,
   input  logic [DATA_W+1:0] host_cmd,
   output logic              host_gnt,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_rvalid,
   output logic [DATA_W+1:0] ram_din,
   output logic              ram_rx_valid,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic              ram_tx_valid,
   output logic [1:0]        owner,
   output logic              spi_overflow,
   output logic              lock_timeout
);

   localparam int CMD_W = DATA_W + 2;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_SPI  = 2'b01;
   localparam logic [1:0] OWN_HOST = 2'b10;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOCK_SPI,
      S_LOCK_HOST,
      S_RD_WAIT
   } state_t;

   state_t            state;
   logic              spi_rx_q;
   logic              spi_pend;
   logic [CMD_W-1:0]  spi_buf;
   logic              last_spi;
   logic              rd_spi;

   logic              spi_rise;
   logic              spi_issue;
   logic              host_issue;
   logic              issue;
   logic [CMD_W-1:0]  issue_cmd;
   logic [1:0]        issue_op;

`ifdef ARB_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMR_W-1:0]  lock_tmr;
`endif

   always_comb begin
      spi_rise   = spi_rx_valid & ~spi_rx_q;
      spi_issue  = 1'b0;
      host_issue = 1'b0;
      case (state)
         // last_spi set means SPI won the previous tie, so the host gets this one
         S_IDLE: begin
            if (spi_pend && (!host_req || !last_spi))
               spi_issue = 1'b1;
            else if (host_req)
               host_issue = 1'b1;
         end
         S_LOCK_SPI:  spi_issue  = spi_pend;
         S_LOCK_HOST: host_issue = host_req;
         default: ;
      endcase
      issue     = spi_issue | host_issue;
      issue_cmd = spi_issue ? spi_buf : host_cmd;
      issue_op  = issue_cmd[CMD_W-1 -: 2];
   end

   assign host_gnt = host_issue;

   // A command arriving in the same cycle the buffer drains replaces it instead of overflowing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spi_rx_q     <= 1'b0;
         spi_pend     <= 1'b0;
         spi_buf      <= '0;
         spi_overflow <= 1'b0;
      end else begin
         spi_rx_q <= spi_rx_valid;
         if (spi_rise && (!spi_pend || spi_issue)) begin
            spi_buf  <= spi_rx_data;
            spi_pend <= 1'b1;
         end else if (spi_issue) begin
            spi_pend <= 1'b0;
         end
         if (spi_rise && spi_pend && !spi_issue)
            spi_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         owner        <= OWN_NONE;
         last_spi     <= 1'b0;
         rd_spi       <= 1'b0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
         spi_tx_data  <= '0;
         spi_tx_valid <= 1'b0;
         host_rdata   <= '0;
         host_rvalid  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         lock_tmr     <= '0;
         lock_timeout <= 1'b0;
`endif
      end else begin
         ram_rx_valid <= 1'b0;
         spi_tx_valid <= 1'b0;
         host_rvalid  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         lock_timeout <= 1'b0;
`endif
         if (issue) begin
            ram_din      <= issue_cmd;
            ram_rx_valid <= 1'b1;
            if (state == S_IDLE)
               last_spi <= spi_issue;
`ifdef ARB_TIMEOUT_EN
            lock_tmr <= TMR_W'(TIMEOUT_CYC);
`endif
            case (issue_op)
               OP_WR_ADDR, OP_RD_ADDR: begin
                  state <= spi_issue ? S_LOCK_SPI : S_LOCK_HOST;
                  owner <= spi_issue ? OWN_SPI : OWN_HOST;
               end
               OP_WR_DATA: begin
                  state <= S_IDLE;
                  owner <= OWN_NONE;
               end
               default: begin
                  state  <= S_RD_WAIT;
                  rd_spi <= spi_issue;
                  owner  <= spi_issue ? OWN_SPI : OWN_HOST;
               end
            endcase
         end else begin
            case (state)
               S_RD_WAIT: begin
                  if (ram_tx_valid) begin
                     if (rd_spi) begin
                        spi_tx_data  <= ram_dout;
                        spi_tx_valid <= 1'b1;
                     end else begin
                        host_rdata  <= ram_dout;
                        host_rvalid <= 1'b1;
                     end
                     state <= S_IDLE;
                     owner <= OWN_NONE;
                  end
               end
`ifdef ARB_TIMEOUT_EN
               S_LOCK_SPI, S_LOCK_HOST: begin
                  if (lock_tmr <= TMR_W'(1)) begin
                     state        <= S_IDLE;
                     owner        <= OWN_NONE;
                     lock_timeout <= 1'b1;
                  end else begin
                     lock_tmr <= lock_tmr - TMR_W'(1);
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

`ifndef ARB_TIMEOUT_EN
   assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: host command table, directed corner sequences, random traffic vs model.
module tb_spi_ram_arbiter;
   localparam int DW   = 8;
   localparam int CW   = DW + 2;
   localparam int TCYC = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] spi_rx_data = '0;
   logic          spi_rx_valid = 1'b0;
   logic [DW-1:0] spi_tx_data;
   logic          spi_tx_valid;
   logic          host_req = 1'b0;
   logic [CW-1:0] host_cmd = '0;
   logic          host_gnt;
   logic [DW-1:0] host_rdata;
   logic          host_rvalid;
   logic [CW-1:0] ram_din;
   logic          ram_rx_valid;
   logic [DW-1:0] ram_dout = '0;
   logic          ram_tx_valid = 1'b0;
   logic [1:0]    owner;
   logic          spi_overflow;
   logic          lock_timeout;

   always #5 clk = ~clk;

   spi_ram_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TCYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
      .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
      .host_req(host_req), .host_cmd(host_cmd), .host_gnt(host_gnt),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
      .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
      .owner(owner), .spi_overflow(spi_overflow), .lock_timeout(lock_timeout)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      #2;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rxv"},  32'(ram_rx_valid), 0);
      chk({tag, "_din"},  32'(ram_din), 0);
      chk({tag, "_own"},  32'(owner), 0);
      chk({tag, "_gnt"},  32'(host_gnt), 0);
      chk({tag, "_stv"},  32'(spi_tx_valid), 0);
      chk({tag, "_std"},  32'(spi_tx_data), 0);
      chk({tag, "_hrv"},  32'(host_rvalid), 0);
      chk({tag, "_hrd"},  32'(host_rdata), 0);
      chk({tag, "_ovf"},  32'(spi_overflow), 0);
      chk({tag, "_to"},   32'(lock_timeout), 0);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      spi_rx_valid = 1'b0; spi_rx_data = '0;
      host_req = 1'b0; host_cmd = '0;
      ram_tx_valid = 1'b0; ram_dout = '0;
      next();
      look();
      chk_zero(tag);
      next();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [CW-1:0] cmd;
      logic [1:0]    own;
   } vec_t;
   vec_t tbl[9];

   // Reference model: lock holder, read wait, one-deep SPI queue, last tie winner.
   int            m_lock, m_rd_who, m_last, m_age;
   bit            m_rd_wait, m_prev_v, m_gnt;
   logic [CW-1:0] m_q[$];
   logic [CW-1:0] e_din;
   logic [1:0]    e_own;
   logic [DW-1:0] e_std, e_hrd;
   bit            e_rxv, e_stv, e_hrv, e_ovf, e_to;

   task automatic model_reset();
      m_lock = 0; m_rd_who = 0; m_last = 2; m_age = 0;
      m_rd_wait = 0; m_prev_v = 0; m_gnt = 0;
      m_q.delete();
      e_din = '0; e_own = '0; e_std = '0; e_hrd = '0;
      e_rxv = 0; e_stv = 0; e_hrv = 0; e_ovf = 0; e_to = 0;
   endtask

   task automatic model_step();
      int            who;
      logic [CW-1:0] cmd;
      who = 0;
      if (!m_rd_wait) begin
         if (m_lock == 0) begin
            if (m_q.size() > 0 && host_req) who = (m_last == 2) ? 1 : 2;
            else if (m_q.size() > 0)        who = 1;
            else if (host_req)              who = 2;
         end else if (m_lock == 1) begin
            if (m_q.size() > 0) who = 1;
         end else if (host_req) begin
            who = 2;
         end
      end
      m_gnt = (who == 2);
      chk("rnd_rxv", 32'(ram_rx_valid), 32'(e_rxv));
      chk("rnd_din", 32'(ram_din), 32'(e_din));
      chk("rnd_own", 32'(owner), 32'(e_own));
      chk("rnd_gnt", 32'(host_gnt), 32'(m_gnt));
      chk("rnd_stv", 32'(spi_tx_valid), 32'(e_stv));
      chk("rnd_std", 32'(spi_tx_data), 32'(e_std));
      chk("rnd_hrv", 32'(host_rvalid), 32'(e_hrv));
      chk("rnd_hrd", 32'(host_rdata), 32'(e_hrd));
      chk("rnd_ovf", 32'(spi_overflow), 32'(e_ovf));
      chk("rnd_to",  32'(lock_timeout), 32'(e_to));

      e_rxv = 0; e_stv = 0; e_hrv = 0; e_to = 0;
      if (who != 0) begin
         cmd = (who == 1) ? m_q.pop_front() : host_cmd;
         if (m_lock == 0) m_last = who;
         e_rxv = 1; e_din = cmd; m_age = 0;
         case (cmd[CW-1 -: 2])
            2'd0, 2'd2: m_lock = who;
            2'd1:       m_lock = 0;
            default: begin m_lock = 0; m_rd_wait = 1; m_rd_who = who; end
         endcase
      end else if (m_rd_wait) begin
         if (ram_tx_valid) begin
            if (m_rd_who == 1) begin e_stv = 1; e_std = ram_dout; end
            else               begin e_hrv = 1; e_hrd = ram_dout; end
            m_rd_wait = 0;
         end
      end else if (m_lock != 0) begin
`ifdef ARB_TIMEOUT_EN
         m_age++;
         if (m_age >= TCYC) begin m_lock = 0; e_to = 1; end
`endif
      end
      if (spi_rx_valid && !m_prev_v) begin
         if (m_q.size() == 0) m_q.push_back(spi_rx_data);
         else                 e_ovf = 1;
      end
      m_prev_v = spi_rx_valid;
      e_own = m_rd_wait ? 2'(m_rd_who) : 2'(m_lock);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int spi_hold, spi_gap, rd_cnt;
      logic [1:0] t5_own;
      logic       t5_to;

      tbl[0] = '{10'h005, 2'b10};
      tbl[1] = '{10'h1A5, 2'b00};
      tbl[2] = '{10'h2AA, 2'b10};
      tbl[3] = '{10'h055, 2'b10};
      tbl[4] = '{10'h1FF, 2'b00};
      tbl[5] = '{10'h134, 2'b00};
      tbl[6] = '{10'h0C3, 2'b10};
      tbl[7] = '{10'h2C4, 2'b10};
      tbl[8] = '{10'h17E, 2'b00};

      do_reset("rst0");

      // host command table, one command per transaction
      for (int i = 0; i < 9; i++) begin
         host_req = 1'b1; host_cmd = tbl[i].cmd;
         look();
         chk($sformatf("tbl%0d_gnt", i), 32'(host_gnt), 1);
         next();
         host_req = 1'b0;
         look();
         chk($sformatf("tbl%0d_rxv", i), 32'(ram_rx_valid), 1);
         chk($sformatf("tbl%0d_din", i), 32'(ram_din), 32'(tbl[i].cmd));
         chk($sformatf("tbl%0d_own", i), 32'(owner), 32'(tbl[i].own));
         next();
      end

      // T1: back-to-back host address + data
      do_reset("t1_rst");
      host_req = 1'b1; host_cmd = 10'h005;
      look(); chk("t1_gnt0", 32'(host_gnt), 1);
      next();
      host_cmd = 10'h1A5;
      look();
      chk("t1_gnt1", 32'(host_gnt), 1);
      chk("t1_rxv0", 32'(ram_rx_valid), 1);
      chk("t1_din0", 32'(ram_din), 32'h005);
      chk("t1_own0", 32'(owner), 2);
      next();
      host_req = 1'b0;
      look();
      chk("t1_rxv1", 32'(ram_rx_valid), 1);
      chk("t1_din1", 32'(ram_din), 32'h1A5);
      chk("t1_own1", 32'(owner), 0);
      next();
      look();
      chk("t1_rxv2", 32'(ram_rx_valid), 0);
      chk("t1_hold", 32'(ram_din), 32'h1A5);
      next();

      // T2: SPI read blocks a pending host request until read data returns
      do_reset("t2_rst");
      spi_rx_valid = 1'b1; spi_rx_data = 10'h203;
      next();
      look();
      chk("t2_rxv_c1", 32'(ram_rx_valid), 0);
      next();
      spi_rx_valid = 1'b0; host_req = 1'b1; host_cmd = 10'h0FF;
      look();
      chk("t2_rxv_c2", 32'(ram_rx_valid), 1);
      chk("t2_din_c2", 32'(ram_din), 32'h203);
      chk("t2_own_c2", 32'(owner), 1);
      chk("t2_gnt_c2", 32'(host_gnt), 0);
      next();
      spi_rx_valid = 1'b1; spi_rx_data = 10'h300;
      look(); chk("t2_gnt_c3", 32'(host_gnt), 0);
      next();
      look(); chk("t2_gnt_c4", 32'(host_gnt), 0);
      next();
      look();
      chk("t2_rxv_c5", 32'(ram_rx_valid), 1);
      chk("t2_din_c5", 32'(ram_din), 32'h300);
      chk("t2_own_c5", 32'(owner), 1);
      chk("t2_gnt_c5", 32'(host_gnt), 0);
      next();
      ram_tx_valid = 1'b1; ram_dout = 8'h5C;
      look();
      chk("t2_gnt_c6", 32'(host_gnt), 0);
      chk("t2_stv_c6", 32'(spi_tx_valid), 0);
      next();
      ram_tx_valid = 1'b0;
      look();
      chk("t2_stv_c7", 32'(spi_tx_valid), 1);
      chk("t2_std_c7", 32'(spi_tx_data), 32'h5C);
      chk("t2_hrv_c7", 32'(host_rvalid), 0);
      chk("t2_own_c7", 32'(owner), 0);
      chk("t2_gnt_c7", 32'(host_gnt), 1);
      next();
      host_req = 1'b0; spi_rx_valid = 1'b0;
      look();
      chk("t2_rxv_c8", 32'(ram_rx_valid), 1);
      chk("t2_din_c8", 32'(ram_din), 32'h0FF);
      chk("t2_own_c8", 32'(owner), 2);
      chk("t2_stv_c8", 32'(spi_tx_valid), 0);
      next();

      // T3: round-robin tie break
      do_reset("t3_rst");
      spi_rx_valid = 1'b1; spi_rx_data = 10'h111;
      next();
      host_req = 1'b1; host_cmd = 10'h122;
      look(); chk("t3_tie1_gnt", 32'(host_gnt), 0);
      next();
      host_req = 1'b0; spi_rx_valid = 1'b0;
      look();
      chk("t3_tie1_din", 32'(ram_din), 32'h111);
      chk("t3_tie1_own", 32'(owner), 0);
      next();
      spi_rx_valid = 1'b1; spi_rx_data = 10'h133;
      next();
      host_req = 1'b1; host_cmd = 10'h144;
      look(); chk("t3_tie2_gnt", 32'(host_gnt), 1);
      next();
      host_req = 1'b0;
      look(); chk("t3_tie2_din", 32'(ram_din), 32'h144);
      next();
      spi_rx_valid = 1'b0;
      look();
      chk("t3_spi_rxv", 32'(ram_rx_valid), 1);
      chk("t3_spi_din", 32'(ram_din), 32'h133);
      next();

      // T4: two SPI commands while host holds the lock
      do_reset("t4_rst");
      host_req = 1'b1; host_cmd = 10'h00A;
      look(); chk("t4_gnt0", 32'(host_gnt), 1);
      next();
      host_req = 1'b0; spi_rx_valid = 1'b1; spi_rx_data = 10'h1B1;
      look(); chk("t4_own", 32'(owner), 2);
      next();
      spi_rx_valid = 1'b0;
      look(); chk("t4_blocked", 32'(ram_rx_valid), 0);
      next();
      spi_rx_valid = 1'b1; spi_rx_data = 10'h1C2;
      look(); chk("t4_ovf_pre", 32'(spi_overflow), 0);
      next();
      spi_rx_valid = 1'b0; host_req = 1'b1; host_cmd = 10'h1DD;
      look();
      chk("t4_ovf_set", 32'(spi_overflow), 1);
      chk("t4_gnt1", 32'(host_gnt), 1);
      next();
      host_req = 1'b0;
      look();
      chk("t4_rel_din", 32'(ram_din), 32'h1DD);
      chk("t4_rel_own", 32'(owner), 0);
      next();
      look();
      chk("t4_spi_rxv", 32'(ram_rx_valid), 1);
      chk("t4_spi_din", 32'(ram_din), 32'h1B1);
      next();
      for (int i = 0; i < 6; i++) begin
         look();
         chk("t4_no_second", 32'(ram_rx_valid), 0);
         chk("t4_ovf_sticky", 32'(spi_overflow), 1);
         next();
      end
      do_reset("t4_clr");

      // T5: idle host lock, released only when the timeout feature is built in
      host_req = 1'b1; host_cmd = 10'h010;
      look(); chk("t5_gnt", 32'(host_gnt), 1);
      next();
      host_req = 1'b0;
      for (int i = 1; i <= 12; i++) begin
`ifdef ARB_TIMEOUT_EN
         t5_own = (i >= TCYC + 1) ? 2'b00 : 2'b10;
         t5_to  = (i == TCYC + 1);
`else
         t5_own = 2'b10;
         t5_to  = 1'b0;
`endif
         look();
         chk($sformatf("t5_own_%0d", i), 32'(owner), 32'(t5_own));
         chk($sformatf("t5_to_%0d", i), 32'(lock_timeout), 32'(t5_to));
         next();
      end
      host_req = 1'b1; host_cmd = 10'h100;
      look(); chk("t5_rel_gnt", 32'(host_gnt), 1);
      next();
      host_req = 1'b0;
      look(); chk("t5_rel_own", 32'(owner), 0);
      next();

      // T6: reset during a host read wait
      do_reset("t6_rst");
      host_req = 1'b1; host_cmd = 10'h2C0;
      look(); chk("t6_gnt0", 32'(host_gnt), 1);
      next();
      host_cmd = 10'h3C1;
      look(); chk("t6_gnt1", 32'(host_gnt), 1);
      next();
      host_req = 1'b0;
      look();
      chk("t6_rd_din", 32'(ram_din), 32'h3C1);
      chk("t6_rd_own", 32'(owner), 2);
      next();
      rst_n = 1'b0;
      look();
      chk_zero("t6_async");
      next();
      rst_n = 1'b1;
      next();
      ram_tx_valid = 1'b1; ram_dout = 8'hAA;
      next();
      ram_tx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         look();
         chk("t6_no_hrv", 32'(host_rvalid), 0);
         chk("t6_no_stv", 32'(spi_tx_valid), 0);
         chk("t6_own", 32'(owner), 0);
         next();
      end

      // random traffic against the reference model
      do_reset("rnd_rst");
      model_reset();
      spi_hold = 0; spi_gap = 0; rd_cnt = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (spi_rx_valid) begin
            if (spi_hold > 0) spi_hold--;
            else begin
               spi_rx_valid = 1'b0;
               spi_gap = $urandom_range(0, 4);
            end
         end else if (spi_gap > 0) begin
            spi_gap--;
         end else if ($urandom_range(0, 3) == 0) begin
            spi_rx_valid = 1'b1;
            spi_rx_data  = CW'($urandom);
            spi_hold     = $urandom_range(1, 5);
         end
         if (!host_req || m_gnt) begin
            host_req = ($urandom_range(0, 2) == 0);
            host_cmd = CW'($urandom);
         end
         ram_tx_valid = 1'b0;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               ram_tx_valid = 1'b1;
               ram_dout = DW'($urandom);
            end
         end
         look();
         model_step();
         if (ram_rx_valid && ram_din[CW-1 -: 2] == 2'b11)
            rd_cnt = $urandom_range(1, 4);
         next();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
